// File: rtl/blit_pkg.sv
// Shared widths and arbiter state encoding for the blitter memory path.
package blit_pkg;

    localparam int ADDR_W      = 26;
    localparam int DATA_W      = 32;
    localparam int BURST_WORDS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BURST = 2'd2
    } arb_state_t;

endpackage

// File: rtl/blit_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: scans from last_grant+1 upward, wrapping modulo N.
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  request,
    input  logic [IW-1:0] last_grant,
    output logic [IW-1:0] winner,
    output logic          any_valid
);

    // Walk the ring backwards so the nearest requester after last_grant is written last.
    always_comb begin
        int idx;
        idx       = 0;
        winner    = last_grant;
        any_valid = 1'b0;
        for (int k = N; k >= 1; k--) begin
            idx       = (int'(last_grant) + k) % N;
            winner    = request[idx] ? IW'(idx) : winner;
            any_valid = any_valid | request[idx];
        end
    end

endmodule

// File: rtl/blit_mem_arbiter.sv
// Shares the burst SDRAM port between blitter memory clients with round-robin
// fairness, grant held from issue to burst completion, and a burst watchdog.
module blit_mem_arbiter
    import blit_pkg::*;
#(
    parameter int NUM_PORTS = 3,
    parameter int TIMEOUT   = 1023
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_address,
    input  logic [NUM_PORTS-1:0]        req_request,
    input  logic [NUM_PORTS-1:0]        req_write,
    input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]        req_ack,
    output logic [NUM_PORTS-1:0]        req_valid,
    output logic [NUM_PORTS-1:0]        req_wready,
    output logic [NUM_PORTS-1:0]        req_complete,
    output logic [DATA_W-1:0]           req_rdata,
    output logic [ADDR_W-1:0]           mem_address,
    output logic                        mem_request,
    output logic                        mem_write,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_data,
    input  logic                        mem_valid,
    input  logic                        mem_ack,
    input  logic                        mem_wready,
    input  logic                        mem_complete,
    output logic                        watchdog_error
);

    localparam int            IW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int            CW        = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] LAST_PORT = IW'(NUM_PORTS - 1);

    arb_state_t           state_r, state_nxt_s;
    logic [IW-1:0]        grant_r, last_grant_r, winner_s;
    logic [CW-1:0]        wd_cnt_r;
    logic [NUM_PORTS-1:0] grant_oh_s, eligible_s;
    logic                 any_s, done_s, timeout_s, launch_s, abort_s;

    assign grant_oh_s = {{(NUM_PORTS-1){1'b0}}, 1'b1} << grant_r;
    // The port finishing its burst is not eligible at its own completion edge.
    assign eligible_s = (state_r == IDLE) ? req_request : (req_request & ~grant_oh_s);
    assign done_s     = ((state_r == BURST) && mem_complete) ||
                        ((state_r == ISSUE) && mem_ack && mem_complete);
    assign timeout_s  = ((state_r == ISSUE) || (state_r == BURST)) &&
                        (wd_cnt_r == CW'(TIMEOUT - 1));
    assign mem_wdata  = req_wdata[int'(grant_r)*DATA_W +: DATA_W];
    assign req_rdata  = mem_data;

    rr_pick #(.N(NUM_PORTS), .IW(IW)) u_rr_pick (
        .request    (eligible_s),
        .last_grant (last_grant_r),
        .winner     (winner_s),
        .any_valid  (any_s)
    );

    // Next-state selection; completion wins over timeout, timeout wins over a late ack.
    always_comb begin
        state_nxt_s = state_r;
        launch_s    = 1'b0;
        abort_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (any_s) begin
                    launch_s    = 1'b1;
                    state_nxt_s = ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE, BURST: begin
                if (done_s) begin
                    launch_s    = any_s;
                    state_nxt_s = any_s ? ISSUE : IDLE;
                end else if (timeout_s) begin
                    abort_s     = 1'b1;
                    state_nxt_s = IDLE;
                end else if ((state_r == ISSUE) && mem_ack) begin
                    state_nxt_s = BURST;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, grant bookkeeping, registered controller request and watchdog.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r        <= IDLE;
            grant_r        <= '0;
            last_grant_r   <= LAST_PORT;
            mem_request    <= 1'b0;
            mem_address    <= '0;
            mem_write      <= 1'b0;
            wd_cnt_r       <= '0;
            watchdog_error <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (launch_s) begin
                grant_r      <= winner_s;
                last_grant_r <= winner_s;
                mem_request  <= 1'b1;
                mem_address  <= req_address[int'(winner_s)*ADDR_W +: ADDR_W];
                mem_write    <= req_write[winner_s];
                wd_cnt_r     <= '0;
            end else if (abort_s) begin
                mem_request    <= 1'b0;
                watchdog_error <= 1'b1;
                wd_cnt_r       <= '0;
            end else begin
                if ((state_r == ISSUE) && mem_ack) begin
                    mem_request <= 1'b0;
                end
                if ((state_r == ISSUE) || (state_r == BURST)) begin
                    wd_cnt_r <= wd_cnt_r + CW'(1);
                end
            end
        end
    end

    // Controller handshakes reach only the granted requester, and only while a burst is live.
    always_comb begin
        req_ack      = '0;
        req_valid    = '0;
        req_wready   = '0;
        req_complete = '0;
        if (state_r == ISSUE) begin
            req_ack = grant_oh_s & {NUM_PORTS{mem_ack}};
        end else begin
            req_ack = '0;
        end
        if ((state_r == ISSUE) || (state_r == BURST)) begin
            req_valid    = grant_oh_s & {NUM_PORTS{mem_valid}};
            req_wready   = grant_oh_s & {NUM_PORTS{mem_wready}};
            req_complete = grant_oh_s & {NUM_PORTS{mem_complete}};
        end else begin
            req_valid    = '0;
            req_wready   = '0;
            req_complete = '0;
        end
    end

endmodule

// File: tb/tb_blit_mem_arbiter.sv
// Self-checking bench for blit_mem_arbiter: the bench plays both the clients and
// the SDRAM controller, predicting grants from the round-robin rule.
`timescale 1ns/1ps
module tb_blit_mem_arbiter;

    localparam int NP = 3;
    localparam int TO = 15;

    logic            clock = 1'b0;
    logic            reset;
    logic [NP*26-1:0] req_address;
    logic [NP-1:0]   req_request, req_write;
    logic [NP*32-1:0] req_wdata;
    logic [NP-1:0]   req_ack, req_valid, req_wready, req_complete;
    logic [31:0]     req_rdata, mem_wdata, mem_data;
    logic [25:0]     mem_address;
    logic            mem_request, mem_write;
    logic            mem_valid, mem_ack, mem_wready, mem_complete;
    logic            watchdog_error;

    always #5 clock = ~clock;

    blit_mem_arbiter #(.NUM_PORTS(NP), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .req_address(req_address), .req_request(req_request), .req_write(req_write),
        .req_wdata(req_wdata), .req_ack(req_ack), .req_valid(req_valid),
        .req_wready(req_wready), .req_complete(req_complete), .req_rdata(req_rdata),
        .mem_address(mem_address), .mem_request(mem_request), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_data(mem_data), .mem_valid(mem_valid),
        .mem_ack(mem_ack), .mem_wready(mem_wready), .mem_complete(mem_complete),
        .watchdog_error(watchdog_error)
    );

    int          checks = 0;
    int          errors = 0;
    logic [2:0]  pend;          // model: requests raised and not yet acknowledged
    int          last_m;        // model: most recently granted port
    logic [25:0] cl_addr [NP];
    logic        cl_wr   [NP];

    typedef struct packed {
        logic [2:0] mask;
        logic [1:0] n;
        logic [5:0] order;      // expected grants, first in [1:0]
    } vec_t;
    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_model(input logic [2:0] pr, input int last);
        int r;
        r = -1;
        for (int k = 1; k <= NP; k++)
            if (r < 0 && pr[(last + k) % NP]) r = (last + k) % NP;
        return r;
    endfunction

    task automatic raise(input int p, input logic [25:0] a, input logic w);
        if (!pend[p]) begin
            cl_addr[p] = a;
            cl_wr[p]   = w;
            req_address[p*26 +: 26] = a;
            req_write[p]   = w;
            req_request[p] = 1'b1;
            pend[p]        = 1'b1;
        end
    endtask

    task automatic wait_issue(output int n);
        n = 0;
        while (mem_request !== 1'b1 && n < 20) begin
            @(negedge clock); #1; n++;
        end
        chk("issue_seen", {63'd0, mem_request}, 64'd1);
    endtask

    // One full burst for port w, starting in the first cycle mem_request is seen.
    task automatic burst(input int w, input int ack_lat, input logic [2:0] add_at_done);
        logic [2:0]  oh;
        logic [2:0]  elig;
        logic [31:0] d;
        int          gap_at;
        oh = 3'b001 << w;
        chk("mem_address", {38'd0, mem_address}, {38'd0, cl_addr[w]});
        chk("mem_write", {63'd0, mem_write}, {63'd0, cl_wr[w]});
        for (int i = 0; i < ack_lat; i++) begin
            @(negedge clock); #1;
            chk("ack_wait", {60'd0, mem_request, req_ack}, {60'd0, 1'b1, 3'b000});
        end
        @(negedge clock); mem_ack = 1'b1; #1;
        chk("req_ack", {61'd0, req_ack}, {61'd0, oh});
        gap_at = $urandom_range(0, 8);
        for (int b = 0; b < 8; b++) begin
            @(negedge clock);
            mem_ack = 1'b0; mem_valid = 1'b0; mem_wready = 1'b0;
            req_request[w] = 1'b0; pend[w] = 1'b0;
            if (b == gap_at) begin
                #1 chk("gap_quiet", {58'd0, req_valid, req_wready}, 64'd0);
                @(negedge clock);
            end
            if (b == 0) #1 chk("req_dropped_after_ack", {63'd0, mem_request}, 64'd0);
            d = $urandom;
            if (cl_wr[w]) begin
                req_wdata[w*32 +: 32] = d; mem_wready = 1'b1; #1;
                chk("req_wready", {61'd0, req_wready}, {61'd0, oh});
                chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, d});
            end else begin
                mem_data = d; mem_valid = 1'b1; #1;
                chk("req_valid", {61'd0, req_valid}, {61'd0, oh});
                chk("req_rdata", {32'd0, req_rdata}, {32'd0, d});
            end
        end
        @(negedge clock);
        mem_valid = 1'b0; mem_wready = 1'b0; mem_complete = 1'b1;
        for (int p = 0; p < NP; p++)
            if (add_at_done[p]) raise(p, 26'($urandom), 1'($urandom));
        #1 chk("req_complete", {61'd0, req_complete}, {61'd0, oh});
        elig = pend & ~oh;
        @(negedge clock); mem_complete = 1'b0; #1;
        chk("next_issue", {63'd0, mem_request}, {63'd0, (elig != 3'b000)});
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        int n_w, w, o, idx;
        logic compl_seen;
        vecs[0] = '{mask: 3'b001, n: 2'd1, order: 6'b00_00_00};
        vecs[1] = '{mask: 3'b111, n: 2'd3, order: 6'b00_10_01};
        vecs[2] = '{mask: 3'b101, n: 2'd2, order: 6'b00_00_10};
        vecs[3] = '{mask: 3'b011, n: 2'd2, order: 6'b00_00_01};
        vecs[4] = '{mask: 3'b110, n: 2'd2, order: 6'b00_10_01};
        vecs[5] = '{mask: 3'b111, n: 2'd3, order: 6'b10_01_00};
        vecs[6] = '{mask: 3'b010, n: 2'd1, order: 6'b00_00_01};
        vecs[7] = '{mask: 3'b100, n: 2'd1, order: 6'b00_00_10};

        reset = 1'b1;
        req_address = '0; req_request = '0; req_write = '0; req_wdata = '0;
        mem_data = '0; mem_valid = 1'b0; mem_ack = 1'b0; mem_wready = 1'b0; mem_complete = 1'b0;
        pend = 3'b000; last_m = NP - 1;
        for (int p = 0; p < NP; p++) begin cl_addr[p] = '0; cl_wr[p] = 1'b0; end

        #13;
        chk("rst_mem", {36'd0, mem_request, mem_write, mem_address}, 64'd0);
        chk("rst_req_out", {52'd0, req_ack, req_valid, req_wready, req_complete}, 64'd0);
        chk("rst_wd", {63'd0, watchdog_error}, 64'd0);
        @(negedge clock); reset = 1'b0;

        // controller handshakes while idle must not be forwarded or start anything
        @(negedge clock);
        mem_valid = 1'b1; mem_wready = 1'b1; mem_complete = 1'b1; mem_ack = 1'b1;
        #1 chk("idle_ignore", {52'd0, req_ack, req_valid, req_wready, req_complete}, 64'd0);
        @(negedge clock);
        mem_valid = 1'b0; mem_wready = 1'b0; mem_complete = 1'b0; mem_ack = 1'b0;
        #1 chk("idle_no_issue", {63'd0, mem_request}, 64'd0);

        // table: simultaneous request sets and the grant order they must produce
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            for (int p = 0; p < NP; p++)
                if (vecs[i].mask[p]) raise(p, 26'h120 + 26'(p * 'h40) + 26'(i * 'h1000), (p == 1));
            for (int k = 0; k < int'(vecs[i].n); k++) begin
                wait_issue(n_w);
                if (k == 0) chk("req_to_issue_latency", 64'(n_w), 64'd1);
                else        chk("b2b_zero_idle", 64'(n_w), 64'd0);
                w = int'((vecs[i].order >> (2 * k)) & 6'd3);
                last_m = w;
                burst(w, k % 3, 3'b000);
            end
        end

        // port 0 keeps requesting, port 2 asks once: grants must go 0, 2, 0
        @(negedge clock);
        raise(0, 26'h0000200, 1'b0); raise(2, 26'h0000300, 1'b1);
        wait_issue(n_w); last_m = 0; burst(0, 1, 3'b001);
        wait_issue(n_w); last_m = 2; burst(2, 0, 3'b001);
        wait_issue(n_w); last_m = 0; burst(0, 0, 3'b000);

        // ack and complete in the same cycle, with another port waiting
        @(negedge clock);
        raise(1, 26'h0000400, 1'b0);
        wait_issue(n_w); last_m = 1;
        @(negedge clock); mem_ack = 1'b1; mem_complete = 1'b1; raise(2, 26'h0000500, 1'b0);
        #1 chk("same_cycle_ack", {58'd0, req_ack, req_complete}, {58'd0, 3'b010, 3'b010});
        @(negedge clock); mem_ack = 1'b0; mem_complete = 1'b0;
        req_request[1] = 1'b0; pend[1] = 1'b0;
        #1 chk("same_cycle_next", {63'd0, mem_request}, 64'd1);
        last_m = 2; burst(2, 0, 3'b000);

        // randomized traffic against the round-robin model
        for (int it = 0; it < 40; it++) begin
            if (pend == 3'b000) begin
                @(negedge clock);
                o = $urandom_range(1, 7);
                for (int p = 0; p < NP; p++)
                    if (o[p]) raise(p, 26'($urandom), 1'($urandom));
            end
            wait_issue(n_w);
            w = rr_model(pend, last_m);
            if (w < 0) w = 0;
            last_m = w;
            burst(w, $urandom_range(0, 2), 3'($urandom));
        end

        // watchdog: controller acks but never completes
        if (pend == 3'b000) begin @(negedge clock); raise(0, 26'h0000600, 1'b0); end
        wait_issue(n_w);
        w = rr_model(pend, last_m); if (w < 0) w = 0; last_m = w;
        o = (w + 1) % NP;
        @(negedge clock); mem_ack = 1'b1; raise(o, 26'h0000700, 1'b0);
        #1 chk("wd_ack", {61'd0, req_ack}, {61'd0, 3'b001 << w});
        @(negedge clock); mem_ack = 1'b0; req_request[w] = 1'b0; pend[w] = 1'b0;
        idx = 2; compl_seen = 1'b0;
        #1;
        while (watchdog_error !== 1'b1 && idx < 40) begin
            if (req_complete != 3'b000) compl_seen = 1'b1;
            @(negedge clock); idx++; #1;
        end
        chk("wd_cycles", 64'(idx), 64'(TO));
        chk("wd_no_complete", {63'd0, compl_seen | (req_complete != 3'b000)}, 64'd0);
        chk("wd_abort_req", {63'd0, mem_request}, 64'd0);
        @(negedge clock); #1;
        chk("wd_next_grant", {63'd0, mem_request}, 64'd1);
        w = rr_model(pend, last_m); if (w < 0) w = 0; last_m = w;
        burst(w, 0, 3'b000);
        chk("wd_sticky", {63'd0, watchdog_error}, 64'd1);

        // reset in the middle of a burst takes effect without a clock edge
        if (pend == 3'b000) begin @(negedge clock); raise(1, 26'h0000800, 1'b0); end
        wait_issue(n_w);
        w = rr_model(pend, last_m); if (w < 0) w = 0;
        @(negedge clock); mem_ack = 1'b1;
        @(negedge clock); mem_ack = 1'b0; req_request[w] = 1'b0; pend[w] = 1'b0;
        mem_valid = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk("rst_async_mem", {62'd0, mem_request, watchdog_error}, 64'd0);
        chk("rst_async_route", {61'd0, req_valid}, 64'd0);
        @(negedge clock);
        mem_valid = 1'b0; req_request = '0; pend = 3'b000; last_m = NP - 1;
        reset = 1'b0;
        @(negedge clock);
        raise(1, 26'h0000900, 1'b0); raise(2, 26'h0000a00, 1'b1); raise(0, 26'h0000b00, 1'b0);
        wait_issue(n_w);
        last_m = 0; burst(0, 0, 3'b000);
        while (pend != 3'b000) begin
            wait_issue(n_w);
            w = rr_model(pend, last_m); if (w < 0) w = 0; last_m = w;
            burst(w, 1, 3'b000);
        end
        chk("post_rst_wd", {63'd0, watchdog_error}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/blit_mem_arbiter.md
# blit_mem_arbiter

Shares the single burst SDRAM port between the blitter-side memory clients: the blitter read cache, the blitter write buffer and a third general client. It holds one requester's grant from issue until burst completion, steers address and write data outward, and routes ack, valid, complete and write-ready back to the granted requester only. Sits between the blitter memory clients and the SDRAM controller. Uses round-robin fairness and a burst watchdog.

## Interface
- NUM_PORTS, 3, number of requesters (2..4); port 0 = blit read cache
- TIMEOUT, 1023, max cycles from grant to mem_complete before watchdog abort
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_address  in  NUM_PORTS*26  per-port burst address; port p uses bits [p*26+:26]; bits [4:0] passed through unmodified
- req_request  in  NUM_PORTS  per-port request level, held until that port's req_ack
- req_write  in  NUM_PORTS  1 = write burst, 0 = read burst
- req_wdata  in  NUM_PORTS*32  per-port write data for the current beat
- req_ack  out  NUM_PORTS  one-hot, request accepted
- req_valid  out  NUM_PORTS  one-hot, read beat on req_rdata
- req_wready  out  NUM_PORTS  one-hot, write beat consumed this cycle
- req_complete  out  NUM_PORTS  one-hot, burst finished
- req_rdata  out  32  broadcast of mem_data
- mem_address  out  26  registered burst address
- mem_request  out  1  registered request
- mem_write  out  1  registered direction
- mem_wdata  out  32  granted port's req_wdata (combinational)
- mem_data  in  32  read data
- mem_valid, mem_ack, mem_wready, mem_complete  in  1 each  controller handshakes
- watchdog_error  out  1  sticky; set on timeout

## Operation
- States: IDLE, ISSUE (mem_request=1, awaiting mem_ack), BURST (awaiting mem_complete).
- IDLE: if any req_request, pick a winner by round-robin starting at last_grant+1 mod NUM_PORTS. At that edge: grant<=winner, last_grant<=winner, mem_request<=1, mem_address/mem_write<=winner's inputs, go to ISSUE.
- ISSUE: req_ack[grant]=mem_ack. On mem_ack: mem_request<=0, go to BURST.
- BURST: on mem_complete, arbitrate again at the same edge. Go to ISSUE if any request is pending (back-to-back), otherwise go to IDLE.
- Routing: req_valid[grant]=mem_valid, req_wready[grant]=mem_wready, req_complete[grant]=mem_complete. This applies only in ISSUE or BURST; all other bits are 0.
- mem_valid, mem_wready, mem_complete or mem_ack arriving in IDLE are ignored and not forwarded.
- mem_ack and mem_complete in the same cycle: treated as ack followed by complete, forwarding both to the grant. The next state follows the BURST-complete rule.
- A request dropped in ISSUE before ack is a protocol violation. The arbiter does not abort; the burst completes and is forwarded normally.
- A request from the granted port re-asserted in the completion cycle is not eligible at that edge. Round-robin already places it last.
- Watchdog: counter cleared on entering ISSUE and incremented each cycle in ISSUE/BURST. On reaching TIMEOUT: watchdog_error<=1, mem_request<=0, state<=IDLE, no req_complete issued.

## Timing
- Reset (async) values:
  - state=IDLE
  - mem_request=0, mem_address=0, mem_write=0
  - last_grant=NUM_PORTS-1, so port 0 wins first
  - watchdog counter=0, watchdog_error=0
  - all req_* outputs 0
- Reset mid-burst abandons the burst. The controller is reset by the same signal.
- Request to mem_request: 1 cycle.
- ack/valid/wready/complete pass through to req_* combinationally, 0 cycles.
- Back-to-back bursts have zero idle cycles between complete and the next mem_request.

## Structure
- Shared package blit_pkg:
  - ADDR_W=26, DATA_W=32, BURST_WORDS=8
  - arb_state_t enum {IDLE, ISSUE, BURST}
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: request vector, last_grant.
  - Outputs: winner index, any-valid.
  - Reused by the display fetch arbiter.

## Test plan
- Single read, port 0, address 0x0000120: mem_request 1 cycle after request, mem_address=0x0000120, mem_write=0. After ack, 8 mem_valid beats appear on req_valid[0] only, then req_complete[0].
- Ports 0, 1, 2 request simultaneously from reset: grants go 0, 1, 2. Each next mem_request is asserted in the cycle after the previous mem_complete, with no IDLE cycle.
- Port 1 write burst: mem_wdata tracks req_wdata[1]. mem_wready pulses appear on req_wready[1] only; req_wready[0] and req_wready[2] stay 0.
- Port 0 requests continuously while port 2 requests once: grants alternate 0, 2, 0. Port 0 never wins twice while port 2 is pending.
- Controller never asserts mem_complete (TIMEOUT=15): watchdog_error rises 15 cycles after entering ISSUE. State returns to IDLE, a pending port is granted next, and no req_complete is issued.
- Reset asserted mid-BURST: mem_request=0 and watchdog_error=0 immediately, without waiting for a clock edge. After release, port 0 wins first.
